window3x3_gen: RTL and testbench

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/window3x3_gen_if.sv | 24 ++
 rtl/window3x3_gen.sv | 146 ++++++++++++++
 tb/tb_window3x3_gen.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window3x3_gen.
// slave = the window generator, master = the surrounding environment.
`timescale 1ns/1ps
interface window3x3_gen_if #(
    parameter int DW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            win_valid;
    logic            win_ready;
    logic [9*DW-1:0] win_data;
    logic            frame_done;

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, frame_done
    );

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, frame_done
    );
endinterface

// File: rtl/window3x3_gen.sv
// Raster pixel stream -> 3x3 sliding windows (no padding) using two line buffers.
// Define WINDOW3X3_GEN_STATS_EN to add win_count, a saturating count of consumed windows.
`timescale 1ns/1ps
module window3x3_gen #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    window3x3_gen_if.slave bus
`ifdef WINDOW3X3_GEN_STATS_EN
    ,
    output logic [15:0] win_count
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                win_valid_q, win_valid_d;
    logic [8:0][DW-1:0]  win_q, win_d;
    logic                frame_done_q, frame_done_d;
    // Two most recent columns of the 3-row stripe, index 0 = top (row-2).
    logic [2:0][DW-1:0]  col1_q, col1_d, col2_q, col2_d;
    logic [2:0][DW-1:0]  col_new;

    logic [DW-1:0] lb0_mem [IMG_W];
    logic [DW-1:0] lb1_mem [IMG_W];

    logic accept, load, last_px;

    assign bus.in_ready   = (!win_valid_q || bus.win_ready) && !clear;
    assign accept         = bus.in_valid && bus.in_ready;
    assign last_px        = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign load           = accept && (state_q == S_RUN) && (col_q >= CW'(2));
    assign col_new        = {bus.in_data, lb1_mem[col_q], lb0_mem[col_q]};
    assign bus.win_valid  = win_valid_q;
    assign bus.win_data   = win_q;
    assign bus.frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        col1_d       = col1_q;
        col2_d       = col2_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            col2_d = col1_q;
            col1_d = col_new;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = last_px ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (last_px) begin
                state_d      = S_FILL;
                frame_done_d = 1'b1;
            end else if ((row_q == RW'(1)) && (col_q == COL_LAST)) begin
                state_d = S_RUN;
            end
        end

        // Consumption frees the slot; a same-cycle load refills it.
        if (bus.win_ready) win_valid_d = 1'b0;
        if (load) begin
            win_valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = col2_q[r];
                win_d[3*r+1] = col1_q[r];
                win_d[3*r+2] = col_new[r];
            end
        end

        if (clear) begin
            state_d      = S_FILL;
            col_d        = '0;
            row_d        = '0;
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_q        <= '0;
            frame_done_q <= 1'b0;
            col1_q       <= '0;
            col2_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_q        <= win_d;
            frame_done_q <= frame_done_d;
            col1_q       <= col1_d;
            col2_q       <= col2_d;
        end
    end

    // Line buffers shift one row down per accepted pixel; rows 0/1 of each
    // frame overwrite them before RUN, so stale rows never reach a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[col_q] <= lb1_mem[col_q];
            lb1_mem[col_q] <= bus.in_data;
        end
    end

`ifdef WINDOW3X3_GEN_STATS_EN
    logic [15:0] win_count_q, win_count_d;

    always_comb begin
        win_count_d = win_count_q;
        if (clear) begin
            win_count_d = '0;
        end else if (win_valid_q && bus.win_ready && (win_count_q != 16'hFFFF)) begin
            win_count_d = win_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) win_count_q <= '0;
        else     win_count_q <= win_count_d;
    end

    assign win_count = win_count_q;
`endif
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 4x4 image: scenario table plus hand-written
// stall / clear / reset sequences, all checked against a frame-array model.
`timescale 1ns/1ps
module tb_window3x3_gen;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    window3x3_gen_if #(.DW(8)) bus ();
`ifdef WINDOW3X3_GEN_STATS_EN
    logic [15:0] win_count;
`endif

    window3x3_gen #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
`ifdef WINDOW3X3_GEN_STATS_EN
        ,
        .win_count (win_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [7:0]  frame_m [W*H];
    logic [71:0] q[$];
    logic [71:0] got_q[$];
    int          pcnt = 0;
    bit          exp_fd = 0;
    bit          prev_stall = 0;
    logic [71:0] prev_data;
    int          n_win = 0;
    int          n_fd = 0;
    bit          ready_auto = 0;
    int          stall_pct = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] w9(input int tl);
        logic [71:0] w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = 8'(tl + W*r + c);
        return w;
    endfunction

    function automatic logic [71:0] win_of(input int r, input int c);
        logic [71:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = frame_m[(r-2+i)*W + (c-2+j)];
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        pcnt       = 0;
        exp_fd     = 0;
        prev_stall = 0;
    endtask

    // Monitor: values are stable at negedge and describe what the next posedge does.
    always @(negedge clk) begin
        if (!rst) begin
            chk("win_valid", {71'b0, bus.win_valid}, {71'b0, q.size() != 0});
            chk("frame_done", {71'b0, bus.frame_done}, {71'b0, exp_fd});
            if (bus.frame_done) n_fd++;
            exp_fd = 0;
            chk("in_ready", {71'b0, bus.in_ready},
                {71'b0, (!bus.win_valid || bus.win_ready) && !clear});
            if (prev_stall) chk("stall_hold", bus.win_data, prev_data);
            prev_stall = bus.win_valid && !bus.win_ready && !clear;
            prev_data  = bus.win_data;
            if (clear) begin
                model_reset();
            end else begin
                if (bus.win_valid && bus.win_ready) begin
                    if (q.size() != 0) chk("window", bus.win_data, q.pop_front());
                    got_q.push_back(bus.win_data);
                    n_win++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    frame_m[pcnt] = bus.in_data;
                    if (pcnt / W >= 2 && pcnt % W >= 2) q.push_back(win_of(pcnt / W, pcnt % W));
                    pcnt++;
                    if (pcnt == W*H) begin
                        pcnt   = 0;
                        exp_fd = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_auto) bus.win_ready = ($urandom_range(99) >= stall_pct);
    end

    task automatic push_pixel(input logic [7:0] v, input int gap_pct);
        int n;
        bit acc;
        while ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: pixel %0d not accepted after %0d cycles", v, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.win_valid || q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: window still pending after %0d cycles", n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic start_test();
        pulse_clear();
        n_win = 0;
        n_fd  = 0;
        got_q.delete();
    endtask

    typedef struct {
        logic [7:0]  base;
        bit          rnd;
        int          gap_pct;
        int          stall_pct;
        int          frames;
        int          exp_win;
        logic [71:0] exp_first;
        logic [71:0] exp_second;  // first window of frame 1
    } scn_t;

    scn_t scn [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scn[0] = '{8'd0, 1'b0, 0,  0,  1, 4,  w9(0), 72'd0};
        scn[1] = '{8'd0, 1'b0, 0,  0,  2, 8,  w9(0), w9(100)};
        scn[2] = '{8'd0, 1'b0, 30, 40, 2, 8,  w9(0), w9(100)};
        scn[3] = '{8'd0, 1'b1, 20, 30, 3, 12, 72'd0, 72'd0};
        scn[4] = '{8'd0, 1'b1, 0,  60, 2, 8,  72'd0, 72'd0};

        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_win_valid", {71'b0, bus.win_valid}, 72'd0);
        chk("rst_win_data", bus.win_data, 72'd0);
        chk("rst_frame_done", {71'b0, bus.frame_done}, 72'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {71'b0, bus.in_ready}, 72'd1);
        @(posedge clk); #1;

        for (int s = 0; s < 5; s++) begin
            start_test();
            ready_auto = 1;
            stall_pct  = scn[s].stall_pct;
            for (int f = 0; f < scn[s].frames; f++)
                for (int i = 0; i < W*H; i++)
                    push_pixel(scn[s].rnd ? 8'($urandom) : 8'(scn[s].base + 100*f + i), scn[s].gap_pct);
            drain();
            chk("scn_win_count", 72'(n_win), 72'(scn[s].exp_win));
            chk("scn_frame_done_count", 72'(n_fd), 72'(scn[s].frames));
            if (!scn[s].rnd) begin
                chk("scn_first_win", got_q[0], scn[s].exp_first);
                if (scn[s].frames > 1) chk("scn_second_frame_win", got_q[4], scn[s].exp_second);
            end
`ifdef WINDOW3X3_GEN_STATS_EN
            chk("stats_win_count", 72'(win_count), 72'(n_win));
`endif
        end

`ifdef WINDOW3X3_GEN_STATS_EN
        pulse_clear();
        chk("stats_after_clear", 72'(win_count), 72'd0);
`endif

        // Downstream stall right at the first window.
        start_test();
        ready_auto = 0;
        bus.win_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < W*H; i++) push_pixel(8'(i), 0);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.win_valid && n < 100);
                chk("stall_wait_first", {71'b0, bus.win_valid}, 72'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("stall_data", bus.win_data, w9(0));
                    chk("stall_in_ready", {71'b0, bus.in_ready}, 72'd0);
                end
                @(posedge clk); #1;
                bus.win_ready = 1'b1;
            end
        join
        drain();
        chk("stall_win_count", 72'(n_win), 72'd4);
        chk("stall_w0", got_q[0], w9(0));
        chk("stall_w1", got_q[1], w9(1));
        chk("stall_w2", got_q[2], w9(4));
        chk("stall_w3", got_q[3], w9(5));

        // Abort a frame after pixel 9, then stream a full frame.
        start_test();
        ready_auto = 1;
        stall_pct = 0;
        for (int i = 0; i < 10; i++) push_pixel(8'(i), 0);
        pulse_clear();
        for (int i = 0; i < W*H; i++) push_pixel(8'(i), 0);
        drain();
        chk("clear_win_count", 72'(n_win), 72'd4);
        chk("clear_fd_count", 72'(n_fd), 72'd1);
        chk("clear_w0", got_q[0], w9(0));
        chk("clear_w3", got_q[3], w9(5));

        // Reset while a window is pending.
        start_test();
        ready_auto = 0;
        bus.win_ready = 1'b0;
        for (int i = 0; i < 11; i++) push_pixel(8'(i), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_win_valid", {71'b0, bus.win_valid}, 72'd0);
        chk("midrst_frame_done", {71'b0, bus.frame_done}, 72'd0);
        chk("midrst_win_data", bus.win_data, 72'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {71'b0, bus.in_ready}, 72'd1);
        n_win = 0;
        n_fd = 0;
        got_q.delete();
        ready_auto = 1;
        stall_pct = 25;
        @(posedge clk); #1;
        for (int i = 0; i < W*H; i++) push_pixel(8'(i), 0);
        drain();
        chk("midrst_win_count", 72'(n_win), 72'd4);
        chk("midrst_fd_count", 72'(n_fd), 72'd1);
        chk("midrst_w0", got_q[0], w9(0));
        chk("midrst_w3", got_q[3], w9(5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
